// File: rtl/sargantana_itag_ctrl.sv
// Instruction-cache tag controller: arbitrates refill writes, two-cycle tag lookups
// and a full invalidate sweep over an external synchronous tag memory.
module sargantana_itag_ctrl #(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_DEPTH      = 64,
  parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
  parameter int TAG_WIDHT      = 20
) (
  input  logic                              clk_i,
  input  logic                              rst_i,

  input  logic                              lookup_valid_i,
  output logic                              lookup_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]         lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]              lookup_tag_i,

  output logic                              resp_valid_o,
  output logic                              resp_hit_o,
  output logic [ICACHE_N_WAY-1:0]           resp_way_o,
  output logic [ICACHE_N_WAY-1:0]           resp_victim_o,

  input  logic                              refill_valid_i,
  output logic                              refill_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0]         refill_idx_i,
  input  logic [TAG_WIDHT-1:0]              refill_tag_i,
  input  logic [ICACHE_N_WAY-1:0]           refill_way_i,

  input  logic                              flush_i,
  output logic                              flush_busy_o,

  output logic [ICACHE_N_WAY-1:0]           mem_req_o,
  output logic                              mem_we_o,
  output logic                              mem_vbit_o,
  output logic [TAG_WIDHT-1:0]              mem_data_o,
  output logic [TAG_ADDR_WIDHT-1:0]         mem_addr_o,
  input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] mem_tag_way_i,
  input  logic [ICACHE_N_WAY-1:0]           mem_vbit_i
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  localparam int PTR_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

  logic [1:0]                state_q, state_d;
  logic                      flush_pending_q;
  logic [TAG_ADDR_WIDHT-1:0] sweep_q;
  logic [PTR_W-1:0]          rr_ptr_q;
  logic [TAG_WIDHT-1:0]      tag_q;

  logic                      is_idle;
  logic                      refill_fire;
  logic                      lookup_fire;
  logic                      sweep_last;
  logic [ICACHE_N_WAY-1:0]   hit_vec;
  logic [ICACHE_N_WAY-1:0]   hit_first;
  logic [ICACHE_N_WAY-1:0]   invalid_vec;
  logic [ICACHE_N_WAY-1:0]   invalid_first;
  logic [ICACHE_N_WAY-1:0]   rr_onehot;
  logic                      all_valid;

  assign is_idle        = (state_q == IDLE);
  assign refill_ready_o = is_idle & ~flush_pending_q;
  assign lookup_ready_o = is_idle & ~flush_pending_q & ~refill_valid_i;
  assign refill_fire    = refill_valid_i & refill_ready_o;
  assign lookup_fire    = lookup_valid_i & lookup_ready_o;
  assign sweep_last     = (sweep_q == TAG_ADDR_WIDHT'(TAG_DEPTH - 1));
  assign flush_busy_o   = (state_q == FLUSH);

  // Isolating the lowest set bit (x & -x) picks the lowest-index hit / free way.
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      hit_vec[w] = mem_vbit_i[w] & (mem_tag_way_i[w*TAG_WIDHT +: TAG_WIDHT] == tag_q);
    end
  end

  assign hit_first     = hit_vec & (~hit_vec + ICACHE_N_WAY'(1));
  assign invalid_vec   = ~mem_vbit_i;
  assign invalid_first = invalid_vec & (~invalid_vec + ICACHE_N_WAY'(1));
  assign all_valid     = &mem_vbit_i;
  assign rr_onehot     = ICACHE_N_WAY'(1) << rr_ptr_q;

  always_comb begin
    mem_req_o  = '0;
    mem_we_o   = 1'b0;
    mem_vbit_o = 1'b0;
    mem_data_o = '0;
    mem_addr_o = '0;
    case (state_q)
      IDLE: begin
        if (refill_fire) begin
          mem_req_o  = refill_way_i;
          mem_we_o   = 1'b1;
          mem_vbit_o = 1'b1;
          mem_data_o = refill_tag_i;
          mem_addr_o = refill_idx_i;
        end else if (lookup_fire) begin
          mem_req_o  = '1;
          mem_addr_o = lookup_idx_i;
        end
      end
      FLUSH: begin
        mem_req_o  = '1;
        mem_we_o   = 1'b1;
        mem_addr_o = sweep_q;
      end
      default: ;
    endcase
  end

  // A flush seen during COMPARE goes straight to FLUSH once the response is issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_pending_q)  state_d = FLUSH;
        else if (lookup_fire) state_d = COMPARE;
      end
      COMPARE: state_d = (flush_pending_q | flush_i) ? FLUSH : IDLE;
      FLUSH:   state_d = sweep_last ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      flush_pending_q <= 1'b0;
      sweep_q         <= '0;
      rr_ptr_q        <= '0;
      tag_q           <= '0;
      resp_valid_o    <= 1'b0;
      resp_hit_o      <= 1'b0;
      resp_way_o      <= '0;
      resp_victim_o   <= '0;
    end else begin
      state_q         <= state_d;
      flush_pending_q <= (state_q == FLUSH) ? 1'b0 : (flush_pending_q | flush_i);
      resp_valid_o    <= 1'b0;
      resp_hit_o      <= 1'b0;
      resp_way_o      <= '0;
      resp_victim_o   <= '0;

      if (lookup_fire) tag_q <= lookup_tag_i;

      if (state_q == COMPARE) begin
        resp_valid_o  <= 1'b1;
        resp_hit_o    <= |hit_vec;
        resp_way_o    <= hit_first;
        resp_victim_o <= all_valid ? rr_onehot : invalid_first;
        if (~|hit_vec & all_valid) begin
          rr_ptr_q <= (rr_ptr_q == PTR_W'(ICACHE_N_WAY - 1)) ? '0 : rr_ptr_q + PTR_W'(1);
        end
      end

      if (state_q == FLUSH) begin
        sweep_q <= sweep_last ? '0 : sweep_q + TAG_ADDR_WIDHT'(1);
        if (sweep_last) rr_ptr_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Scoreboard bench for sargantana_itag_ctrl: a cache-contents model predicts every
// lookup response, and a separate monitor compares them as the DUT presents them.
module tb_sargantana_itag_ctrl;

  localparam int N  = 4;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int TW = 20;

  typedef struct {
    logic         hit;
    logic [N-1:0] way;
    logic [N-1:0] victim;
    int           cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            lookup_valid = 1'b0;
  logic            lookup_ready;
  logic [AW-1:0]   lookup_idx = '0;
  logic [TW-1:0]   lookup_tag = '0;
  logic            resp_valid, resp_hit;
  logic [N-1:0]    resp_way, resp_victim;
  logic            refill_valid = 1'b0;
  logic            refill_ready;
  logic [AW-1:0]   refill_idx = '0;
  logic [TW-1:0]   refill_tag = '0;
  logic [N-1:0]    refill_way = '0;
  logic            flush = 1'b0;
  logic            flush_busy;
  logic [N-1:0]    mem_req;
  logic            mem_we, mem_vbit;
  logic [TW-1:0]   mem_data;
  logic [AW-1:0]   mem_addr;
  logic [N*TW-1:0] rd_tag;
  logic [N-1:0]    rd_vbit;

  logic [TW-1:0]   tmem [N][D];
  logic            vmem [N][D];

  logic [TW-1:0]   m_tag   [N][D];
  bit              m_valid [N][D];
  int              m_ptr = 0;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sargantana_itag_ctrl #(
    .ICACHE_N_WAY(N), .TAG_DEPTH(D), .TAG_ADDR_WIDHT(AW), .TAG_WIDHT(TW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .lookup_valid_i(lookup_valid), .lookup_ready_o(lookup_ready),
    .lookup_idx_i(lookup_idx), .lookup_tag_i(lookup_tag),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit),
    .resp_way_o(resp_way), .resp_victim_o(resp_victim),
    .refill_valid_i(refill_valid), .refill_ready_o(refill_ready),
    .refill_idx_i(refill_idx), .refill_tag_i(refill_tag), .refill_way_i(refill_way),
    .flush_i(flush), .flush_busy_o(flush_busy),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_vbit_o(mem_vbit),
    .mem_data_o(mem_data), .mem_addr_o(mem_addr),
    .mem_tag_way_i(rd_tag), .mem_vbit_i(rd_vbit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous tag RAM with one-cycle read latency; starts empty after reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < N; w++) begin
        for (int a = 0; a < D; a++) begin
          tmem[w][a] <= '0;
          vmem[w][a] <= 1'b0;
        end
      end
      rd_tag  <= '0;
      rd_vbit <= '0;
    end else begin
      for (int w = 0; w < N; w++) begin
        if (mem_req[w]) begin
          if (mem_we) begin
            tmem[w][mem_addr] <= mem_data;
            vmem[w][mem_addr] <= mem_vbit;
          end else begin
            rd_tag[w*TW +: TW] <= tmem[w][mem_addr];
            rd_vbit[w]         <= vmem[w][mem_addr];
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response rules applied to the modelled set contents.
  task automatic modelLookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag, output exp_t e);
    bit all = 1'b1;
    e.hit = 1'b0; e.way = '0; e.victim = '0; e.cyc = 0;
    for (int w = 0; w < N; w++) begin
      if (m_valid[w][idx] && m_tag[w][idx] == tag && !e.hit) begin
        e.hit = 1'b1;
        e.way[w] = 1'b1;
      end
      if (!m_valid[w][idx]) begin
        if (all) e.victim[w] = 1'b1;
        all = 1'b0;
      end
    end
    if (all) e.victim = N'(1) << m_ptr;
    if (!e.hit && all) m_ptr = (m_ptr + 1) % N;
  endtask

  task automatic modelRefill(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [N-1:0] way);
    for (int w = 0; w < N; w++) begin
      if (way[w]) begin
        m_tag[w][idx]   = tag;
        m_valid[w][idx] = 1'b1;
      end
    end
  endtask

  task automatic doRefill(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [N-1:0] way);
    bit ok = 1'b0;
    refill_valid = 1'b1; refill_idx = idx; refill_tag = tag; refill_way = way;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (refill_ready) begin
        ok = 1'b1;
        checkOutput("refill_mem", {mem_req, mem_we, mem_vbit, mem_data, mem_addr},
                    {way, 1'b1, 1'b1, tag, idx});
        modelRefill(idx, tag, way);
      end
      @(posedge clk); #1;
    end
    refill_valid = 1'b0;
    checkOutput("refill_accept", ok, 1);
  endtask

  task automatic doLookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag);
    bit ok = 1'b0;
    exp_t e;
    lookup_valid = 1'b1; lookup_idx = idx; lookup_tag = tag;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (lookup_ready) begin
        ok = 1'b1;
        checkOutput("lookup_mem", {mem_req, mem_we, mem_addr}, {{N{1'b1}}, 1'b0, idx});
        modelLookup(idx, tag, e);
        e.cyc = cyc + 2;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    lookup_valid = 1'b0;
    checkOutput("lookup_accept", ok, 1);
  endtask

  // in_compare: caller has just had a lookup accepted, so this cycle is COMPARE.
  task automatic doFlush(input bit in_compare);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (!in_compare) begin
      @(negedge clk);
      checkOutput("flush_pending", {flush_busy, lookup_ready, refill_ready, mem_req}, '0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      checkOutput("flush_sweep", {flush_busy, lookup_ready, mem_req, mem_we, mem_vbit, mem_addr},
                  {1'b1, 1'b0, {N{1'b1}}, 1'b1, 1'b0, AW'(i)});
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("flush_done", {flush_busy, lookup_ready}, 2'b01);
    @(posedge clk); #1;
    for (int w = 0; w < N; w++)
      for (int a = 0; a < D; a++) m_valid[w][a] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic applyStimulus(input int op);
    logic [AW-1:0] idx = AW'($urandom_range(0, 7));
    logic [TW-1:0] tag = 20'h50000 | TW'($urandom_range(0, 3));
    if (op < 35) begin
      doRefill(idx, tag, N'(1) << $urandom_range(0, N - 1));
    end else if (op < 95) begin
      doLookup(idx, tag);
    end else if (op < 97) begin
      @(posedge clk); #1;
      doFlush(1'b0);
    end else begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every due scoreboard entry must coincide with a response strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        checkOutput("resp_valid", resp_valid, 1);
        checkOutput("resp_fields", {resp_hit, resp_way, resp_victim},
                    {mon_e.hit, mon_e.way, mon_e.victim});
      end else if (resp_valid) begin
        checkOutput("resp_unexpected", resp_valid, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int w = 0; w < N; w++)
      for (int a = 0; a < D; a++) begin
        m_valid[w][a] = 1'b0;
        m_tag[w][a]   = '0;
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {resp_valid, resp_hit, resp_way, resp_victim, flush_busy, mem_req}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", {lookup_ready, refill_ready, flush_busy}, 3'b110);
    @(posedge clk); #1;

    $display("[TB] refill then hit");
    doRefill(6'd5, 20'hABCDE, 4'b0010);
    doLookup(6'd5, 20'hABCDE);
    @(posedge clk); #1;

    $display("[TB] miss on empty set");
    doLookup(6'd3, 20'h11111);
    @(posedge clk); #1;

    $display("[TB] round-robin victims on full set");
    for (int w = 0; w < N; w++) doRefill(6'd7, 20'h70000 + TW'(w), N'(1) << w);
    for (int k = 0; k < 5; k++) doLookup(6'd7, 20'h7FFFF);
    @(posedge clk); #1;

    $display("[TB] refill and lookup together");
    refill_valid = 1'b1; refill_idx = 6'd9; refill_tag = 20'h99999; refill_way = 4'b0001;
    lookup_valid = 1'b1; lookup_idx = 6'd9; lookup_tag = 20'h99999;
    @(negedge clk);
    checkOutput("simul_ready", {lookup_ready, refill_ready}, 2'b01);
    checkOutput("simul_write", {mem_req, mem_we, mem_vbit, mem_data, mem_addr},
                {4'b0001, 1'b1, 1'b1, 20'h99999, 6'd9});
    modelRefill(6'd9, 20'h99999, 4'b0001);
    @(posedge clk); #1;
    refill_valid = 1'b0;
    doLookup(6'd9, 20'h99999);
    @(posedge clk); #1;

    $display("[TB] flush from idle");
    doFlush(1'b0);
    doLookup(6'd5, 20'hABCDE);
    @(posedge clk); #1;

    $display("[TB] flush during compare");
    doRefill(6'd2, 20'h22222, 4'b0100);
    doLookup(6'd2, 20'h22222);
    doFlush(1'b1);
    doLookup(6'd2, 20'h22222);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) applyStimulus($urandom_range(0, 99));

    for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
    @(negedge clk);
    checkOutput("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
